// File: rtl/median_window_if.sv
// Ready/valid bus between the frame source, the window buffer and the median core.
// The slave modport is the window buffer; the master modport is the source/consumer side.
interface median_window_if #(
    parameter int WORD_W   = 32,
    parameter int WIN_ROWS = 3,
    parameter int ADDR_W   = 10,
    parameter int RC_W     = 2
);
    logic                         start;
    logic                         in_valid;
    logic                         in_ready;
    logic [WORD_W-1:0]            in_word;
    logic                         out_valid;
    logic                         out_ready;
    logic [WIN_ROWS*WORD_W-1:0]   out_col;
    logic [ADDR_W-1:0]            waddr;
    logic [RC_W-1:0]              window_line_counter;
    logic                         end_of_operation;

    modport slave (
        input  start, in_valid, in_word, out_ready,
        output in_ready, out_valid, out_col, waddr, window_line_counter, end_of_operation
    );

    modport master (
        output start, in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_col, waddr, window_line_counter, end_of_operation
    );
endinterface

// File: rtl/median_window_buffer.sv
// Line-buffer / window assembler: emits one column of WIN_ROWS vertically aligned
// words per accepted input word once WIN_ROWS-1 lines have been buffered.
module median_window_buffer #(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int LINE_WORDS   = 57,
    parameter int IMG_LINES    = 228,
    parameter int WIN_ROWS     = 3,
    parameter int ADDR_W       = 10
) (
    input  logic            clk,
    input  logic            rst,
    median_window_if.slave  bus
);
    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int RC_W   = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
    localparam int WA_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int LN_W   = $clog2(IMG_LINES + 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t                              state_q, state_d;
    logic [ADDR_W-1:0]                   wcnt;
    logic [LN_W-1:0]                     line_cnt;
    logic [RC_W-1:0]                     row_ptr;
    logic                                out_valid_q;
    logic                                last_q;
    logic [WIN_ROWS-1:0][WORD_W-1:0]     out_col_q;
    logic [ADDR_W-1:0]                   waddr_q;

    // One storage row per window line; row_ptr holds the line being written,
    // which is also the slot of the oldest line that just fell out of the window.
    logic [WORD_W-1:0]                   line_mem [WIN_ROWS][LINE_WORDS];

    logic [WIN_ROWS-1:0][WORD_W-1:0]     col_d;
    logic [WIN_ROWS-2:0][RC_W-1:0]       rd_row;
    logic [WA_W-1:0]                     widx;
    logic                                in_rdy, accept, out_fire;
    logic                                word_last, fill_done, frame_last, in_open;

    assign widx       = wcnt[WA_W-1:0];
    assign word_last  = (wcnt == ADDR_W'(LINE_WORDS - 1));
    assign fill_done  = (state_q == FILL) && accept && word_last &&
                        (line_cnt == LN_W'(WIN_ROWS - 2));
    assign frame_last = word_last && (line_cnt == LN_W'(IMG_LINES - 1));
    assign in_open    = (state_q == FILL) ||
                        ((state_q == STREAM) && (line_cnt < LN_W'(IMG_LINES)));
    assign in_rdy     = in_open && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_rdy;
    assign out_fire   = out_valid_q && bus.out_ready;

    // Slice k reads line (current - WIN_ROWS + 1 + k), i.e. row (row_ptr + 1 + k) mod WIN_ROWS.
    for (genvar k = 0; k < WIN_ROWS - 1; k++) begin : g_rd
        assign rd_row[k] = (row_ptr >= RC_W'(WIN_ROWS - 1 - k)) ?
                           row_ptr - RC_W'(WIN_ROWS - 1 - k) :
                           row_ptr + RC_W'(k + 1);
        assign col_d[k]  = line_mem[rd_row[k]][widx];
    end
    assign col_d[WIN_ROWS-1] = bus.in_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)         state_d = FILL;
            FILL:    if (fill_done)         state_d = STREAM;
            STREAM:  if (out_fire && last_q) state_d = DONE;
            DONE:                           state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt        <= '0;
            line_cnt    <= '0;
            row_ptr     <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            out_col_q   <= '0;
            waddr_q     <= '0;
        end else if (state_q == IDLE && bus.start) begin
            wcnt        <= '0;
            line_cnt    <= '0;
            row_ptr     <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            if (accept) begin
                if (word_last) begin
                    wcnt     <= '0;
                    line_cnt <= line_cnt + LN_W'(1);
                    row_ptr  <= (row_ptr == RC_W'(WIN_ROWS - 1)) ? '0 : row_ptr + RC_W'(1);
                end else begin
                    wcnt     <= wcnt + ADDR_W'(1);
                end
            end
            // Accept is only possible when the output slot is free or draining,
            // so loading here never overwrites an unconsumed column.
            if (accept && state_q == STREAM) begin
                out_col_q   <= col_d;
                waddr_q     <= wcnt;
                out_valid_q <= 1'b1;
                last_q      <= frame_last;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset; FILL rewrites every word before it is read.
    always_ff @(posedge clk) begin
        if (accept) line_mem[row_ptr][widx] <= bus.in_word;
    end

    assign bus.in_ready            = in_rdy;
    assign bus.out_valid           = out_valid_q;
    assign bus.out_col             = out_col_q;
    assign bus.waddr               = waddr_q;
    assign bus.window_line_counter = row_ptr;
    assign bus.end_of_operation    = (state_q == DONE);
endmodule

// File: tb/tb_median_window_buffer.sv
// Randomised bench for median_window_buffer with a frame-level reference model
// (4 words/line, 5 lines, 3-row window, word = line*16 + addr).
module tb_median_window_buffer;
    localparam int LW     = 4;
    localparam int NL     = 5;
    localparam int WR     = 3;
    localparam int WORD_W = 32;
    localparam int NWORDS = LW * NL;
    localparam int NFILL  = LW * (WR - 1);
    localparam int NCOLS  = LW * (NL - WR + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    median_window_if #(.WORD_W(WORD_W), .WIN_ROWS(WR), .ADDR_W(10), .RC_W(2)) bus ();

    median_window_buffer #(
        .PIX_W(8), .PIX_PER_WORD(4), .LINE_WORDS(LW), .IMG_LINES(NL),
        .WIN_ROWS(WR), .ADDR_W(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // model state
    int   in_idx = 0;
    int   col_idx = 0;
    int   frames_done = 0;
    logic started = 1'b0;
    logic eoo_exp = 1'b0;

    // stimulus knobs
    logic rnd_in = 1'b0, rnd_out = 1'b0, stall_en = 1'b0, stall_done = 1'b0;
    int   stall_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pix_word(input int line, input int addr);
        return 32'(line * 16 + addr);
    endfunction

    function automatic logic [31:0] word_at(input int idx);
        if (idx < NWORDS) return pix_word(idx / LW, idx % LW);
        return 32'hDEAD_0000 | 32'(idx);
    endfunction

    // Column n covers current line 2+n/LW; oldest line in the low slice.
    function automatic logic [95:0] exp_col(input int n);
        int l, a;
        l = (WR - 1) + n / LW;
        a = n % LW;
        return {pix_word(l, a), pix_word(l - 1, a), pix_word(l - 2, a)};
    endfunction

    // Compare process: samples 1 ns before each rising edge.
    always @(negedge clk) begin
        int   pending;
        logic exp_rdy, cur_eoo;
        #4;
        if (rst) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_waddr", bus.waddr, 0);
            chk("rst_eoo", bus.end_of_operation, 0);
            chk("rst_wlc", bus.window_line_counter, 0);
            chk("rst_out_col", bus.out_col, 0);
            in_idx = 0; col_idx = 0; started = 1'b0; eoo_exp = 1'b0;
        end else begin
            pending = ((in_idx > NFILL) ? in_idx - NFILL : 0) - col_idx;
            exp_rdy = started && (in_idx < NWORDS) && (pending == 0 || bus.out_ready);
            cur_eoo = eoo_exp;
            eoo_exp = 1'b0;
            chk("out_valid", bus.out_valid, pending > 0);
            chk("in_ready", bus.in_ready, exp_rdy);
            chk("eoo", bus.end_of_operation, cur_eoo);
            chk("wlc", bus.window_line_counter, (in_idx / LW) % WR);
            if (bus.out_valid && pending > 0) begin
                chk("out_col", bus.out_col, exp_col(col_idx));
                chk("waddr", bus.waddr, col_idx % LW);
                if (col_idx == 1) begin
                    chk("pin_col_l2a1", bus.out_col, 96'h00000021_00000011_00000001);
                    chk("pin_waddr_1", bus.waddr, 1);
                end
                if (col_idx == NCOLS - 1) begin
                    chk("pin_col_l4a3", bus.out_col, 96'h00000043_00000033_00000023);
                    chk("pin_waddr_3", bus.waddr, 3);
                end
            end
            if (bus.in_valid && bus.in_ready) in_idx++;
            if (bus.out_valid && bus.out_ready && pending > 0) begin
                col_idx++;
                if (col_idx == NCOLS) eoo_exp = 1'b1;
            end
            if (bus.start && !started && !cur_eoo) begin
                started = 1'b1; in_idx = 0; col_idx = 0;
            end
            if (cur_eoo) begin
                chk("col_count", col_idx, 12);
                started = 1'b0;
                frames_done++;
            end
        end
    end

    // Input/output driver
    always @(negedge clk) begin
        bus.in_valid = rnd_in ? ($urandom_range(3) != 0) : 1'b1;
        bus.in_word  = word_at(in_idx);
        if (!started) stall_done = 1'b0;
        if (stall_en && !stall_done && col_idx == 5 && bus.out_valid) begin
            stall_cnt  = 5;
            stall_done = 1'b1;
        end
        if (stall_cnt > 0) begin
            bus.out_ready = 1'b0;
            stall_cnt--;
        end else begin
            bus.out_ready = rnd_out ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    task automatic pulse_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic wait_frame();
        int f0, n;
        f0 = frames_done; n = 0;
        while (frames_done == f0 && n < 500) begin @(negedge clk); n++; end
        chk("frame_done", frames_done - f0, 1);
    endtask

    task automatic wait_cols(input int c);
        int n;
        n = 0;
        while (col_idx < c && n < 500) begin @(negedge clk); n++; end
        chk("cols_reached", col_idx >= c, 1);
    endtask

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_word = '0; bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // clean frame, source always valid, consumer always ready
        pulse_start();
        wait_frame();
        repeat (3) @(negedge clk);

        // random handshakes, 5-cycle stall mid-line, ignored start mid-stream
        rnd_in = 1'b1; rnd_out = 1'b1; stall_en = 1'b1;
        pulse_start();
        wait_cols(4);
        pulse_start();
        wait_frame();
        stall_en = 1'b0; rnd_in = 1'b0; rnd_out = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the middle of STREAM
        pulse_start();
        wait_cols(3);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // fresh random frame after the abort
        rnd_in = 1'b1; rnd_out = 1'b1;
        pulse_start();
        wait_frame();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
